// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop,
        StHalt
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [1:0] i_lsbs);
        return i_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output register with a dominant synchronous clear.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_fault,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_fault
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_pc;
    logic             r_fault;

    // Load wins over a same-cycle drain so back-to-back refills keep the entry full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
            r_fault <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
            r_fault <= i_fault;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
    assign o_fault = r_fault;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request per PC, one-entry output buffer,
// flush/drop handling and a halt state for misaligned PCs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] NOP_INSTR  = ADDR_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  pc_inc,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [ADDR_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_fault
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [ADDR_WIDTH-1:0] w_req_pc_next;

    logic                  w_can_issue;
    logic                  w_buf_load;
    logic [ADDR_WIDTH-1:0] w_buf_data;
    logic [ADDR_WIDTH-1:0] w_buf_pc;
    logic                  w_buf_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_req_pc <= '0;
        end else begin
            r_state  <= w_state_next;
            r_req_pc <= w_req_pc_next;
        end
    end

    // Only issue when the buffer will have room at the edge the response could land.
    assign w_can_issue = (r_state == StIdle) && !flush && (!instr_valid || instr_ready);

    always_comb begin
        w_state_next  = r_state;
        w_req_pc_next = r_req_pc;
        w_buf_load    = 1'b0;
        w_buf_data    = imem_rdata;
        w_buf_pc      = r_req_pc;
        w_buf_fault   = 1'b0;
        pc_inc        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_can_issue) begin
                    if (is_word_aligned(pc_value[1:0])) begin
                        w_req_pc_next = pc_value;
                        w_state_next  = StWait;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_buf_data   = NOP_INSTR;
                        w_buf_pc     = pc_value;
                        w_buf_fault  = 1'b1;
                        w_state_next = StHalt;
                    end
                end
            end
            StWait: begin
                if (flush) begin
                    w_state_next = imem_ack ? StIdle : StDrop;
                end else if (imem_ack) begin
                    w_buf_load   = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StDrop: begin
                if (imem_ack) begin
                    w_state_next = StIdle;
                end
            end
            StHalt: begin
                if (flush) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign imem_req  = (r_state == StWait) || (r_state == StDrop);
    assign imem_addr = r_req_pc;

    fetch_out_buf #(
        .WIDTH (ADDR_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_load  (w_buf_load),
        .i_data  (w_buf_data),
        .i_pc    (w_buf_pc),
        .i_fault (w_buf_fault),
        .i_ready (instr_ready),
        .o_valid (instr_valid),
        .o_data  (instr_data),
        .o_pc    (instr_pc),
        .o_fault (instr_fault)
    );

endmodule
